// File: rtl/perf_cnt_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : perf_cnt_pkg
// Brief    : Shared state encoding, event indices and default widths for the
//            CPU statistics counter bank.
// Revision : 1.0 - initial release
// ============================================================================
package perf_cnt_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;

    localparam int EVT_CYCLE     = 0;
    localparam int EVT_JMP       = 1;
    localparam int EVT_BR_TAKEN  = 2;
    localparam int EVT_BR_NTAKEN = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2,
        CLEAR  = 2'd3
    } state_t;

endpackage : perf_cnt_pkg
`default_nettype wire

// File: rtl/perf_cnt_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : perf_cnt_ctrl_if
// Brief    : Control/event/read-port bundle between the CPU core, the counter
//            controller and the display multiplexer.
// Revision : 1.0 - initial release
// ============================================================================
interface perf_cnt_ctrl_if
    import perf_cnt_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int NUM_EVT    = 4,
    parameter int SEL_W      = 2
);
    logic                  start;
    logic                  halt;
    logic                  clear;
    logic [NUM_EVT-1:0]    evt_req;
    logic [SEL_W-1:0]      rd_sel;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  running;
    logic [NUM_EVT-1:0]    overflow;

    modport master (
        output start, halt, clear, evt_req, rd_sel,
        input  rd_data, running, overflow
    );

    modport slave (
        input  start, halt, clear, evt_req, rd_sel,
        output rd_data, running, overflow
    );
endinterface : perf_cnt_ctrl_if
`default_nettype wire

// File: rtl/perf_cnt_ctrl_evt_counter.sv
`default_nettype none
// ============================================================================
// Module   : evt_counter
// Brief    : Single event counter with sync clear; wraps by default, saturates
//            when PERF_SAT_EN is defined. wrap pulses on an event at max value.
// Revision : 1.0 - initial release
// ============================================================================
module evt_counter
    import perf_cnt_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic                  en,
    input  wire logic                  clr,
    output logic      [DATA_WIDTH-1:0] value,
    output logic                       wrap
);
    logic [DATA_WIDTH-1:0] r_value;
    logic                  w_at_max;

    assign w_at_max = &r_value;
    assign wrap     = en & w_at_max & ~clr;
    assign value    = r_value;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= '0;
        end else if (clr) begin
            r_value <= '0;
        end else if (en) begin
`ifdef PERF_SAT_EN
            if (!w_at_max) begin
                r_value <= r_value + 1'b1;
            end
`else
            r_value <= r_value + 1'b1;
`endif
        end
    end
endmodule : evt_counter
`default_nettype wire

// File: rtl/perf_cnt_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : perf_cnt_ctrl
// Brief    : Run/halt/clear sequencer for the CPU statistics counter bank with a
//            registered indexed read port. Optional macro: PERF_SAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module perf_cnt_ctrl
    import perf_cnt_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int NUM_EVT    = 4,
    parameter int SEL_W      = 2
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    perf_cnt_ctrl_if.slave bus
);
    state_t                r_state;
    logic                  w_run;
    logic                  w_clr;
    logic [DATA_WIDTH-1:0] w_cnt [NUM_EVT];
    logic [NUM_EVT-1:0]    w_wrap;
    logic [NUM_EVT-1:0]    r_overflow;
    logic [DATA_WIDTH-1:0] w_rd_mux;
    logic [DATA_WIDTH-1:0] r_rd_data;

    assign w_run = (r_state == RUN);
    assign w_clr = (r_state == CLEAR);

    // Priority within each state: clear > halt > start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.clear)      r_state <= CLEAR;
                    else if (bus.start) r_state <= RUN;
                end
                RUN: begin
                    if (bus.clear)     r_state <= CLEAR;
                    else if (bus.halt) r_state <= HALTED;
                end
                HALTED: begin
                    if (bus.clear)                    r_state <= CLEAR;
                    else if (bus.start && !bus.halt)  r_state <= RUN;
                end
                CLEAR:   r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_EVT; gi++) begin : g_evt
            evt_counter #(
                .DATA_WIDTH(DATA_WIDTH)
            ) u_evt_counter (
                .clk  (clk),
                .rst_n(rst_n),
                .en   (w_run & bus.evt_req[gi]),
                .clr  (w_clr),
                .value(w_cnt[gi]),
                .wrap (w_wrap[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= '0;
        end else if (w_clr) begin
            r_overflow <= '0;
        end else begin
            r_overflow <= r_overflow | w_wrap;
        end
    end

    // Out-of-range selects match no counter and read as zero.
    always_comb begin
        w_rd_mux = '0;
        for (int i = 0; i < NUM_EVT; i++) begin
            if (bus.rd_sel == SEL_W'(i)) begin
                w_rd_mux = w_cnt[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= w_rd_mux;
        end
    end

    assign bus.rd_data  = r_rd_data;
    assign bus.running  = w_run;
    assign bus.overflow = r_overflow;
endmodule : perf_cnt_ctrl
`default_nettype wire

// File: tb/tb_perf_cnt_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_perf_cnt_ctrl
// Brief    : Self-checking bench driving three controller configurations in
//            lockstep against a behavioural model. Honours PERF_SAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_perf_cnt_ctrl;

`ifdef PERF_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    // Configurations: 0 = 16-bit x4, 1 = 4-bit x4, 2 = 4-bit x3.
    localparam int MW [3] = '{16, 4, 4};
    localparam int MN [3] = '{4, 4, 3};

    typedef enum {M_IDLE, M_RUN, M_HALT, M_CLR} mode_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    perf_cnt_ctrl_if #(.DATA_WIDTH(16), .NUM_EVT(4), .SEL_W(2)) ifa ();
    perf_cnt_ctrl_if #(.DATA_WIDTH(4),  .NUM_EVT(4), .SEL_W(2)) ifb ();
    perf_cnt_ctrl_if #(.DATA_WIDTH(4),  .NUM_EVT(3), .SEL_W(2)) ifc ();

    perf_cnt_ctrl #(.DATA_WIDTH(16), .NUM_EVT(4), .SEL_W(2)) ua (.clk(clk), .rst_n(rst_n), .bus(ifa));
    perf_cnt_ctrl #(.DATA_WIDTH(4),  .NUM_EVT(4), .SEL_W(2)) ub (.clk(clk), .rst_n(rst_n), .bus(ifb));
    perf_cnt_ctrl #(.DATA_WIDTH(4),  .NUM_EVT(3), .SEL_W(2)) uc (.clk(clk), .rst_n(rst_n), .bus(ifc));

    mode_t       m_mode;
    int unsigned m_cnt [3][4];
    logic [3:0]  m_ovf [3];
    logic [31:0] m_rd  [3];

    int checks   = 0;
    int failures = 0;

    function automatic logic [31:0] get_rd(input int k);
        case (k)
            0:       return {16'b0, ifa.rd_data};
            1:       return {28'b0, ifb.rd_data};
            default: return {28'b0, ifc.rd_data};
        endcase
    endfunction

    function automatic logic [3:0] get_ovf(input int k);
        case (k)
            0:       return ifa.overflow;
            1:       return ifb.overflow;
            default: return {1'b0, ifc.overflow};
        endcase
    endfunction

    function automatic logic get_run(input int k);
        case (k)
            0:       return ifa.running;
            1:       return ifb.running;
            default: return ifc.running;
        endcase
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE;
        for (int k = 0; k < 3; k++) begin
            m_ovf[k] = 4'b0;
            m_rd[k]  = 32'd0;
            for (int i = 0; i < 4; i++) m_cnt[k][i] = 0;
        end
    endtask

    // One clock edge of the specified behaviour, using pre-edge model state.
    task automatic model_step(input logic s, input logic h, input logic c,
                              input logic [3:0] e, input logic [1:0] sel);
        int unsigned maxv;
        for (int k = 0; k < 3; k++) begin
            m_rd[k] = (int'(sel) < MN[k]) ? m_cnt[k][sel] : 32'd0;
            maxv = (32'd1 << MW[k]) - 1;
            for (int i = 0; i < MN[k]; i++) begin
                if (m_mode == M_RUN && e[i]) begin
                    if (m_cnt[k][i] == maxv) begin
                        m_ovf[k][i] = 1'b1;
                        m_cnt[k][i] = SAT ? maxv : 0;
                    end else begin
                        m_cnt[k][i] = m_cnt[k][i] + 1;
                    end
                end else if (m_mode == M_CLR) begin
                    m_cnt[k][i] = 0;
                end
            end
            if (m_mode == M_CLR) m_ovf[k] = 4'b0;
        end
        if (m_mode == M_CLR)                 m_mode = M_IDLE;
        else if (c)                          m_mode = M_CLR;
        else if (m_mode == M_IDLE && s)      m_mode = M_RUN;
        else if (m_mode == M_RUN && h)       m_mode = M_HALT;
        else if (m_mode == M_HALT && s && !h) m_mode = M_RUN;
    endtask

    task automatic compare_all(input string tag);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (get_run(k) !== (m_mode == M_RUN)) begin
                failures++;
                $display("FAIL %s dut%0d running got=%b exp=%b", tag, k, get_run(k), (m_mode == M_RUN));
            end
            checks++;
            if (get_ovf(k) !== m_ovf[k]) begin
                failures++;
                $display("FAIL %s dut%0d overflow got=%b exp=%b", tag, k, get_ovf(k), m_ovf[k]);
            end
            checks++;
            if (get_rd(k) !== m_rd[k]) begin
                failures++;
                $display("FAIL %s dut%0d rd_data got=%0d exp=%0d", tag, k, get_rd(k), m_rd[k]);
            end
        end
    endtask

    task automatic set_in(input logic s, input logic h, input logic c,
                          input logic [3:0] e, input logic [1:0] sel);
        ifa.start = s; ifa.halt = h; ifa.clear = c; ifa.evt_req = e;      ifa.rd_sel = sel;
        ifb.start = s; ifb.halt = h; ifb.clear = c; ifb.evt_req = e;      ifb.rd_sel = sel;
        ifc.start = s; ifc.halt = h; ifc.clear = c; ifc.evt_req = e[2:0]; ifc.rd_sel = sel;
    endtask

    task automatic tick(input logic s, input logic h, input logic c,
                        input logic [3:0] e, input logic [1:0] sel, input string tag);
        set_in(s, h, c, e, sel);
        @(posedge clk);
        model_step(s, h, c, e, sel);
        #1;
        compare_all(tag);
    endtask

    task automatic clear_to_idle();
        tick(1'b0, 1'b0, 1'b1, 4'b0, 2'd0, "clr");
        tick(1'b0, 1'b0, 1'b0, 4'b0, 2'd0, "clr_idle");
    endtask

    task automatic test_reset();
        set_in(1'b0, 1'b0, 1'b0, 4'b0, 2'd0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        compare_all("post_reset");
        tick(1'b1, 1'b0, 1'b0, 4'b0, 2'd0, "rst_start");
        for (int i = 0; i < 25; i++) tick(1'b0, 1'b0, 1'b0, 4'b0001, 2'd0, "rst_cnt");
        tick(1'b0, 1'b0, 1'b0, 4'b0001, 2'd0, "rst_rd");
        checks++;
        if (ifa.rd_data !== 16'd25) begin
            failures++;
            $display("FAIL rst_pre_cnt rd_data got=%0d exp=25", ifa.rd_data);
        end
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (ifa.running !== 1'b0 || ifa.overflow !== 4'b0 || ifa.rd_data !== 16'd0 ||
            ifb.overflow !== 4'b0 || ifb.rd_data !== 4'd0) begin
            failures++;
            $display("FAIL rst_async run=%b ovf=%b rd=%0d exp all zero", ifa.running, ifa.overflow, ifa.rd_data);
        end
        compare_all("rst_async");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0, 4'b1111, 2'd0, "rst_idle");
        checks++;
        if (ifa.rd_data !== 16'd0 || ifa.running !== 1'b0) begin
            failures++;
            $display("FAIL rst_idle_hold rd=%0d run=%b exp 0/0", ifa.rd_data, ifa.running);
        end
    endtask

    task automatic test_basic_count();
        clear_to_idle();
        tick(1'b1, 1'b0, 1'b0, 4'b0, 2'd0, "bc_start");
        for (int i = 0; i < 10; i++)
            tick(1'b0, 1'b0, 1'b0, {2'b00, (i == 2 || i == 5 || i == 8), 1'b1}, 2'd0, "bc_evt");
        tick(1'b0, 1'b1, 1'b0, 4'b0, 2'd0, "bc_halt");
        checks++;
        if (ifa.running !== 1'b0) begin
            failures++;
            $display("FAIL bc_running got=%b exp=0", ifa.running);
        end
        tick(1'b0, 1'b0, 1'b0, 4'b0, 2'd0, "bc_rd0");
        checks++;
        if (ifa.rd_data !== 16'd10) begin
            failures++;
            $display("FAIL bc_cnt0 got=%0d exp=10", ifa.rd_data);
        end
        tick(1'b0, 1'b0, 1'b0, 4'b0, 2'd1, "bc_rd1");
        checks++;
        if (ifa.rd_data !== 16'd3) begin
            failures++;
            $display("FAIL bc_cnt1 got=%0d exp=3", ifa.rd_data);
        end
    endtask

    task automatic test_halt_resume();
        clear_to_idle();
        tick(1'b1, 1'b0, 1'b0, 4'b0, 2'd0, "hr_start");
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 1'b0, 4'b0001, 2'd0, "hr_evt");
        tick(1'b0, 1'b1, 1'b0, 4'b0, 2'd0, "hr_halt");
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b0, 4'b0001, 2'd0, "hr_frozen");
        tick(1'b1, 1'b1, 1'b0, 4'b0001, 2'd0, "hr_both");
        tick(1'b1, 1'b0, 1'b0, 4'b0, 2'd0, "hr_resume");
        for (int i = 0; i < 2; i++) tick(1'b0, 1'b0, 1'b0, 4'b0001, 2'd0, "hr_evt2");
        tick(1'b0, 1'b0, 1'b0, 4'b0, 2'd0, "hr_rd");
        checks++;
        if (ifa.rd_data !== 16'd7) begin
            failures++;
            $display("FAIL hr_cnt0 got=%0d exp=7", ifa.rd_data);
        end
    endtask

    task automatic test_priority();
        clear_to_idle();
        tick(1'b1, 1'b0, 1'b0, 4'b0, 2'd0, "pr_start");
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0, 4'b0100, 2'd2, "pr_evt");
        tick(1'b1, 1'b1, 1'b1, 4'b0100, 2'd2, "pr_all");
        tick(1'b1, 1'b0, 1'b0, 4'b0100, 2'd2, "pr_clear");
        checks++;
        if (ifa.running !== 1'b0 || ifa.overflow !== 4'b0) begin
            failures++;
            $display("FAIL pr_idle run=%b ovf=%b exp 0/0", ifa.running, ifa.overflow);
        end
        for (int s = 0; s < 4; s++) begin
            tick(1'b0, 1'b0, 1'b0, 4'b0100, 2'(s), "pr_rd");
            checks++;
            if (ifa.rd_data !== 16'd0 || ifa.running !== 1'b0) begin
                failures++;
                $display("FAIL pr_zero sel=%0d rd=%0d run=%b exp 0/0", s, ifa.rd_data, ifa.running);
            end
        end
    endtask

    task automatic test_wrap_and_bounds();
        logic [31:0] exp_c1;
        clear_to_idle();
        tick(1'b1, 1'b0, 1'b0, 4'b0, 2'd0, "wr_start");
        for (int i = 0; i < 17; i++) tick(1'b0, 1'b0, 1'b0, 4'b1000, 2'd0, "wr_evt");
        tick(1'b0, 1'b0, 1'b0, 4'b0, 2'd3, "wr_rd");
        checks++;
        if (ifb.rd_data !== (SAT ? 4'd15 : 4'd1) || ifb.overflow[3] !== 1'b1) begin
            failures++;
            $display("FAIL wr_cnt3 rd=%0d ovf3=%b exp=%0d/1", ifb.rd_data, ifb.overflow[3], (SAT ? 15 : 1));
        end
        checks++;
        if (ifc.rd_data !== 4'd0 || ifa.rd_data !== 16'd17) begin
            failures++;
            $display("FAIL wr_bounds rd_c=%0d rd_a=%0d exp 0/17", ifc.rd_data, ifa.rd_data);
        end
        tick(1'b0, 1'b0, 1'b0, 4'b0011, 2'd0, "rs_sel0");
        exp_c1 = m_cnt[0][1];
        tick(1'b0, 1'b0, 1'b0, 4'b0011, 2'd1, "rs_sel1");
        checks++;
        if ({16'b0, ifa.rd_data} !== exp_c1) begin
            failures++;
            $display("FAIL rs_switch rd=%0d exp=%0d", ifa.rd_data, exp_c1);
        end
    endtask

    task automatic test_random();
        logic s, h, c;
        for (int n = 0; n < 600; n++) begin
            s = ($urandom_range(0, 99) < 30);
            h = ($urandom_range(0, 99) < 10);
            c = ($urandom_range(0, 99) < 3);
            tick(s, h, c, 4'($urandom), 2'($urandom), "rand");
        end
    endtask

    initial begin
        test_reset();
        test_basic_count();
        test_halt_resume();
        test_priority();
        test_wrap_and_bounds();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_perf_cnt_ctrl
`default_nettype wire
